// File: rtl/savomax_pkg.sv
// rtl/savomax_pkg.sv - shared format codes, state encoding and ms-to-cycle helper
package savomax_pkg;

  typedef enum logic [2:0] {
    FORMAT_UNKNOWN = 3'b000,
    FORMAT_NTSC    = 3'b010,
    FORMAT_PAL     = 3'b100
  } format_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_LOST    = 3'd5
  } state_t;

  function automatic logic [31:0] ms_to_cyc(input int clk_freq, input int ms);
    return 32'((clk_freq / 1000) * ms);
  endfunction

endpackage

// File: rtl/savomax_period_meter.sv
// rtl/savomax_period_meter.sv - vsync synchronizer, falling-edge detect and saturating period counter
module savomax_period_meter
  import savomax_pkg::*;
#(
  parameter logic [31:0] MIN_CYC = ms_to_cyc(250_000, 10),
  parameter logic [31:0] TO_CYC  = ms_to_cyc(250_000, 40)
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clear,
  input  logic        run,
  input  logic        vsync_in,
  output logic        edge_accept,
  output logic        timeout,
  output logic [31:0] period_meas,
  output logic [31:0] period_out
);

  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic        fall;
  logic [31:0] cnt;

  assign fall        = sync3 & ~sync2;
  assign period_meas = cnt + 32'd1;
  // Too-short periods are treated as glitches: the counter keeps running from the last good edge.
  assign edge_accept = fall & run & (period_meas >= MIN_CYC);
  assign timeout     = run & (cnt == TO_CYC);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      cnt        <= 32'd0;
      period_out <= 32'd0;
    end else begin
      sync1 <= vsync_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (clear) begin
        cnt        <= 32'd0;
        period_out <= 32'd0;
      end else if (!run) begin
        cnt <= 32'd0;
      end else if (edge_accept) begin
        cnt        <= 32'd0;
        period_out <= period_meas;
      end else if (cnt != TO_CYC) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/savomax_mode_seq.sv
// rtl/savomax_mode_seq.sv - PAL/NTSC detector with confirmation filter and downstream mode handshake
module savomax_mode_seq
  import savomax_pkg::*;
#(
  parameter int CLK_FREQ          = 250_000,
  parameter int NTSC_PAL_TRESHOLD = 18,
  parameter int MIN_PERIOD_MS     = 10,
  parameter int TIMEOUT_MS        = 40,
  parameter int CONFIRM_COUNT     = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        vsync_in,
  input  logic        mode_ack_in,
  output logic [2:0]  format_out,
  output logic        format_valid_out,
  output logic        mode_req_out,
  output logic        lost_out,
  output logic [31:0] period_out
);

  localparam logic [31:0] TH_CYC      = ms_to_cyc(CLK_FREQ, NTSC_PAL_TRESHOLD);
  localparam logic [31:0] MIN_CYC     = ms_to_cyc(CLK_FREQ, MIN_PERIOD_MS);
  localparam logic [31:0] TO_CYC      = ms_to_cyc(CLK_FREQ, TIMEOUT_MS);
  localparam logic [7:0]  CONFIRM_MAX = 8'(CONFIRM_COUNT);

  state_t      state;
  format_t     cand;
  logic [7:0]  confirm_cnt;
  logic        run;
  logic        edge_accept;
  logic        timeout;
  logic [31:0] period_meas;
  format_t     edge_fmt;
  format_t     next_cand;
  logic [7:0]  next_cnt;
  logic        go_lost;

  assign run = (state != ST_IDLE);

  savomax_period_meter #(
    .MIN_CYC(MIN_CYC),
    .TO_CYC (TO_CYC)
  ) u_meter (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clear      (!enable_in),
    .run        (run),
    .vsync_in   (vsync_in),
    .edge_accept(edge_accept),
    .timeout    (timeout),
    .period_meas(period_meas),
    .period_out (period_out)
  );

  always_comb begin
    edge_fmt  = (period_meas > TH_CYC) ? FORMAT_PAL : FORMAT_NTSC;
    next_cand = cand;
    next_cnt  = 8'd1;
    if (edge_fmt == cand) begin
      next_cnt = (confirm_cnt >= CONFIRM_MAX) ? CONFIRM_MAX : confirm_cnt + 8'd1;
    end else begin
      next_cand = edge_fmt;
    end
  end

  // A simultaneous accepted edge proves the signal is alive, so it overrides the timeout.
  assign go_lost = timeout & ~edge_accept &
                   (state inside {ST_ARM, ST_MEASURE, ST_CONFIRM, ST_UPDATE});

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= ST_IDLE;
      cand             <= FORMAT_UNKNOWN;
      confirm_cnt      <= 8'd0;
      format_out       <= FORMAT_UNKNOWN;
      format_valid_out <= 1'b0;
      mode_req_out     <= 1'b0;
      lost_out         <= 1'b0;
    end else if (!enable_in) begin
      state            <= ST_IDLE;
      cand             <= FORMAT_UNKNOWN;
      confirm_cnt      <= 8'd0;
      format_out       <= FORMAT_UNKNOWN;
      format_valid_out <= 1'b0;
      mode_req_out     <= 1'b0;
      lost_out         <= 1'b0;
    end else if (go_lost) begin
      state            <= ST_LOST;
      confirm_cnt      <= 8'd0;
      format_out       <= FORMAT_UNKNOWN;
      format_valid_out <= 1'b0;
      mode_req_out     <= 1'b0;
      lost_out         <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ARM;
        ST_ARM: begin
          if (edge_accept) state <= ST_MEASURE;
        end
        ST_MEASURE, ST_CONFIRM: begin
          if (edge_accept) begin
            cand <= next_cand;
            if (next_cnt < CONFIRM_MAX) begin
              confirm_cnt <= next_cnt;
              state       <= ST_CONFIRM;
            end else if ((next_cand != format_out) || !format_valid_out) begin
              confirm_cnt      <= next_cnt;
              format_out       <= next_cand;
              format_valid_out <= 1'b0;
              mode_req_out     <= 1'b1;
              state            <= ST_UPDATE;
            end else begin
              confirm_cnt <= CONFIRM_MAX;
              state       <= ST_MEASURE;
            end
          end
        end
        ST_UPDATE: begin
          if (mode_ack_in) begin
            mode_req_out     <= 1'b0;
            format_valid_out <= 1'b1;
            confirm_cnt      <= 8'd0;
            state            <= ST_MEASURE;
          end
        end
        ST_LOST: begin
          if (edge_accept) begin
            lost_out <= 1'b0;
            state    <= ST_ARM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_savomax_mode_seq.sv
// tb/tb_savomax_mode_seq.sv - self-checking bench with a frame-level reference model
module tb_savomax_mode_seq;

  localparam int CLK_FREQ = 25_000;
  localparam int TH_CYC   = (CLK_FREQ / 1000) * 18;
  localparam int MIN_CYC  = (CLK_FREQ / 1000) * 10;
  localparam int TO_CYC   = (CLK_FREQ / 1000) * 40;
  localparam int CC       = 4;
  localparam int PAL_P    = 500;
  localparam int NTSC_P   = 417;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_UPD  = 3;
  localparam int P_LOST = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        enable_in = 1'b0;
  logic        vsync_in = 1'b1;
  logic        mode_ack_in = 1'b0;
  logic [2:0]  format_out;
  logic        format_valid_out;
  logic        mode_req_out;
  logic        lost_out;
  logic [31:0] period_out;

  int errors = 0;
  int checks = 0;

  int m_phase, m_fmt, m_valid, m_req, m_lost, m_cand, m_cnt, m_period, m_acc;
  bit auto_ack;
  int req_age;

  always #5 clk_in = ~clk_in;

  savomax_mode_seq #(
    .CLK_FREQ         (CLK_FREQ),
    .NTSC_PAL_TRESHOLD(18),
    .MIN_PERIOD_MS    (10),
    .TIMEOUT_MS       (40),
    .CONFIRM_COUNT    (CC)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .enable_in       (enable_in),
    .vsync_in        (vsync_in),
    .mode_ack_in     (mode_ack_in),
    .format_out      (format_out),
    .format_valid_out(format_valid_out),
    .mode_req_out    (mode_req_out),
    .lost_out        (lost_out),
    .period_out      (period_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_format"}, 32'(format_out), m_fmt);
    chk({tag, "_valid"}, 32'(format_valid_out), m_valid);
    chk({tag, "_req"}, 32'(mode_req_out), m_req);
    chk({tag, "_lost"}, 32'(lost_out), m_lost);
    chk({tag, "_period"}, period_out, m_period);
  endtask

  task automatic m_reset();
    m_phase = P_IDLE; m_fmt = 0; m_valid = 0; m_req = 0; m_lost = 0;
    m_cand = 0; m_cnt = 0; m_period = 0; m_acc = 0;
  endtask

  // m_acc counts cycles since the last accepted edge, aligned so a new edge measures exactly m_acc.
  task automatic m_fall();
    int r;
    if (m_phase == P_IDLE || m_acc < MIN_CYC) return;
    m_period = ((m_acc - 1 > TO_CYC) ? TO_CYC : m_acc - 1) + 1;
    m_acc = 0;
    case (m_phase)
      P_ARM: m_phase = P_RUN;
      P_LOST: begin m_lost = 0; m_phase = P_ARM; end
      P_RUN: begin
        r = (m_period > TH_CYC) ? 4 : 2;
        if (r == m_cand) m_cnt = (m_cnt < CC) ? m_cnt + 1 : CC;
        else begin m_cand = r; m_cnt = 1; end
        if (m_cnt == CC && (m_cand != m_fmt || m_valid == 0)) begin
          m_fmt = m_cand; m_valid = 0; m_req = 1; m_phase = P_UPD;
        end
      end
      default: ;
    endcase
  endtask

  task automatic m_ack();
    if (m_phase == P_UPD) begin
      m_req = 0; m_valid = 1; m_cnt = 0; m_phase = P_RUN;
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    if (mode_ack_in) begin
      mode_ack_in = 1'b0;
      req_age = 0;
      m_ack();
    end else if (auto_ack && mode_req_out) begin
      req_age++;
      if (req_age >= 2) mode_ack_in = 1'b1;
    end else begin
      req_age = 0;
    end
    if (m_acc < 1_000_000) m_acc++;
    if ((m_phase == P_ARM || m_phase == P_RUN || m_phase == P_UPD) && m_acc == TO_CYC + 4) begin
      m_fmt = 0; m_valid = 0; m_req = 0; m_lost = 1; m_cnt = 0; m_phase = P_LOST;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start();
    enable_in = 1'b1;
    m_phase = P_ARM;
    m_acc = 2;
  endtask

  task automatic disable_run();
    enable_in = 1'b0;
    mode_ack_in = 1'b0;
    req_age = 0;
    tick();
    m_reset();
  endtask

  // One frame: falling edge now, optional glitch edge g cycles later, next frame starts p cycles later.
  task automatic frame(input int p, input int g);
    vsync_in = 1'b0;
    m_fall();
    for (int i = 1; i <= p; i++) begin
      tick();
      if (i == 4) begin
        vsync_in = 1'b1;
        check_all("edge");
      end
      if (g > 0 && i == g) begin
        vsync_in = 1'b0;
        m_fall();
      end
      if (g > 0 && i == g + 4) vsync_in = 1'b1;
    end
    check_all("frame_end");
  endtask

  initial begin
    int sel;
    m_reset();
    auto_ack = 1'b1;
    req_age = 0;

    idle(3);
    check_all("reset");
    rst_n_in = 1'b1;
    idle(2);
    check_all("disabled_idle");

    // Lock PAL from cold start, then hold it.
    start();
    idle(300);
    for (int k = 0; k < 8; k++) frame(PAL_P, 0);
    chk("pal_locked_format", 32'(format_out), 4);
    chk("pal_locked_valid", 32'(format_valid_out), 1);

    // Switch to NTSC, then exercise the threshold boundary.
    for (int k = 0; k < 5; k++) frame(NTSC_P, 0);
    chk("ntsc_locked_format", 32'(format_out), 2);
    for (int k = 0; k < 4; k++) frame(TH_CYC, 0);
    for (int k = 0; k < 5; k++) frame(TH_CYC + 1, 0);
    chk("th_plus1_format", 32'(format_out), 4);

    // Glitches and the minimum-period boundary.
    for (int k = 0; k < 3; k++) frame(PAL_P, 30);
    frame(PAL_P, 0);
    frame(MIN_CYC - 1, 0);
    frame(MIN_CYC + 1, 0);
    frame(MIN_CYC, 0);
    frame(PAL_P, 0);
    frame(PAL_P, 0);

    // Alternating formats never confirm.
    disable_run();
    check_all("disable");
    start();
    idle(300);
    for (int k = 0; k < 10; k++) begin
      frame(NTSC_P, 0);
      frame(PAL_P, 0);
    end
    chk("alt_no_valid", 32'(format_valid_out), 0);

    // Signal loss and recovery.
    disable_run();
    start();
    idle(300);
    for (int k = 0; k < 6; k++) frame(PAL_P, 0);
    idle(TO_CYC + 3 - PAL_P);
    check_all("pre_timeout");
    idle(1);
    check_all("timeout");
    idle(50);
    for (int k = 0; k < 6; k++) frame(PAL_P, 0);
    chk("relock_valid", 32'(format_valid_out), 1);

    // Randomized frame mix.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      auto_ack = ($urandom_range(0, 9) != 0);
      case (sel)
        0: frame(PAL_P, 0);
        1: frame(NTSC_P, 0);
        2: frame(TH_CYC, 0);
        3: frame(TH_CYC + 1, 0);
        4: frame($urandom_range(MIN_CYC + 10, 900), 0);
        default: frame(PAL_P, $urandom_range(10, 200));
      endcase
    end

    // Reset while a request is outstanding and never acknowledged.
    auto_ack = 1'b0;
    disable_run();
    start();
    idle(300);
    for (int k = 0; k < 5; k++) frame(PAL_P, 0);
    chk("pre_reset_req", 32'(mode_req_out), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_reset_req", 32'(mode_req_out), 0);
    chk("async_reset_format", 32'(format_out), 0);
    chk("async_reset_period", period_out, 0);
    m_reset();
    tick();
    rst_n_in = 1'b1;
    check_all("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/savomax_mode_seq.md
SAVOMAX_MODE_SEQ -- requirements
Module: savomax_mode_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 250_000, clock frequency in Hz.
REQ-002 SHALL have parameter NTSC_PAL_TRESHOLD, default 18, PAL/NTSC boundary period in ms; TH_CYC = (CLK_FREQ/1000)*NTSC_PAL_TRESHOLD.
REQ-003 SHALL have parameter MIN_PERIOD_MS, default 10, glitch-reject floor; MIN_CYC = (CLK_FREQ/1000)*MIN_PERIOD_MS.
REQ-004 SHALL have parameter TIMEOUT_MS, default 40, signal-lost limit; TO_CYC = (CLK_FREQ/1000)*TIMEOUT_MS.
REQ-005 SHALL have parameter CONFIRM_COUNT, default 4, consecutive agreeing periods required before a format change.
REQ-006 clk_in  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-008 enable_in  input  1  run when high; low forces IDLE synchronously.
REQ-009 vsync_in  input  1  asynchronous VSYNC; frame start on falling edge.
REQ-010 mode_ack_in  input  1  downstream acknowledge of mode_req_out.
REQ-011 format_out  output  3  000 UNKNOWN, 010 NTSC, 100 PAL.
REQ-012 format_valid_out  output  1  high while format_out is confirmed and acknowledged.
REQ-013 mode_req_out  output  1  format-change request to downstream sync switch.
REQ-014 lost_out  output  1  high after timeout with no VSYNC edge.
REQ-015 period_out  output  32  last accepted period in clk_in cycles.

Function
REQ-016 vsync_in SHALL pass a 2-FF synchronizer; a falling edge SHALL be flagged 3 cycles after the input edge (sync + edge register).
REQ-017 Period counter (32-bit) SHALL increment every cycle outside IDLE, saturate at TO_CYC, and on an accepted edge capture its value plus 1 into period_out and restart at 0.
REQ-018 An edge with captured period < MIN_CYC SHALL be ignored: counter not restarted, no classification.
REQ-019 Classification SHALL be PAL if period > TH_CYC, else NTSC (period == TH_CYC is NTSC).
REQ-020 States: IDLE, ARM, MEASURE, CONFIRM, UPDATE, LOST.
REQ-021 IDLE -> ARM when enable_in high; ARM waits first accepted edge (no classification) -> MEASURE.
REQ-022 MEASURE: each accepted edge classifies; result equal to candidate increments confirm count, otherwise candidate <= result, confirm count <= 1; state -> CONFIRM while count < CONFIRM_COUNT.
REQ-023 When confirm count reaches CONFIRM_COUNT: if candidate != format_out or format_valid_out low -> UPDATE; else stay MEASURE, count held at CONFIRM_COUNT.
REQ-024 UPDATE entry: format_out <= candidate, format_valid_out <= 0, mode_req_out <= 1 on the same cycle.
REQ-025 mode_req_out SHALL stay high until mode_ack_in sampled high; next cycle mode_req_out <= 0, format_valid_out <= 1, -> MEASURE, confirm count <= 0.
REQ-026 Edges during UPDATE SHALL restart the counter and update period_out but SHALL NOT classify.
REQ-027 Counter reaching TO_CYC in ARM, MEASURE, CONFIRM or UPDATE -> LOST: format_out <= 000, format_valid_out <= 0, mode_req_out <= 0, lost_out <= 1, confirm count <= 0.
REQ-028 LOST -> ARM on next accepted edge, lost_out <= 0 on that cycle.
REQ-029 Timeout and accepted edge in same cycle: edge wins.
REQ-030 enable_in low from any state: next cycle IDLE, all outputs to reset values, counter 0.

Reset
REQ-031 rst_n_in low SHALL immediately force IDLE, format_out 000, format_valid_out 0, mode_req_out 0, lost_out 0, period_out 0, counters and synchronizer 0; reset mid-UPDATE drops mode_req_out without waiting for ack.
REQ-032 Deassertion SHALL take effect on the first clk_in rising edge after release.

Structure
REQ-033 Format codes (FORMAT_UNKNOWN/NTSC/PAL), state encodings and ms-to-cycle conversion SHALL live in shared package savomax_pkg.
REQ-034 Synchronizer, edge detect and saturating counter SHALL be sub-module savomax_period_meter; FSM, confirm logic and handshake stay in top.

Verification (CLK_FREQ 250_000: TH_CYC 4500, MIN_CYC 2500, TO_CYC 10000)
REQ-035 VSYNC period 5000 cycles, ack 2 cycles after req -> after 5th edge mode_req_out high, format_out 100; format_valid_out 1 after ack; period_out 5000.
REQ-036 Lock PAL, switch to period 4171 -> format stays 100 until 4 NTSC periods, then req with format_out 010.
REQ-037 Alternating 4171/5000 periods -> no mode_req_out ever; format_valid_out stays 0.
REQ-038 Locked PAL, stop VSYNC -> 10000 cycles after last edge lost_out 1, format_out 000; resume 5000 -> relock after 5 edges.
REQ-039 Glitch pulse 300 cycles after a valid edge in 5000-cycle stream -> ignored, period_out stays 5000, no confirm reset.
REQ-040 rst_n_in low during UPDATE with mode_ack_in never asserted -> mode_req_out 0 immediately, state IDLE.
